// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned UART_CLKS_PER_BIT = 54;
    localparam int unsigned UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_sync.sv
// Metastability flop chain for an asynchronous level input; resets to 1 (line idle).
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 serial receiver: start-bit glitch rejection, framing-error pulse, break handling
// and a one-cycle strobe per correctly framed byte.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      uart_rx,
    output logic [UART_DATA_BITS-1:0] uart_data,
    output logic                      uart_data_rdy,
    output logic                      framing_err,
    output logic                      rx_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    logic rx_s;

    rx_state_t                 state_q,   state_d;
    logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q,   shift_d;
    logic [UART_DATA_BITS-1:0] data_q,    data_d;
    logic                      rdy_q,     rdy_d;
    logic                      ferr_q,    ferr_d;
    logic                      busy_q,    busy_d;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (uart_rx),
        .q    (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        rdy_d     = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_CNT) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                // Counter restarts on each sample so it never has to wrap past LAST_CNT.
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (clk_cnt_q == LAST_CNT) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                clk_cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            rdy_q     <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign uart_data     = data_q;
    assign uart_data_rdy = rdy_q;
    assign framing_err   = ferr_q;
    assign rx_busy       = busy_q;

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Asynchronous 8N1 serial receiver feeding the image-capture path.
- Sits between the board `uart_rx` pin and `uart_to_img`. It produces one byte per frame plus a single-cycle `uart_data_rdy` strobe, which drives both the pixel write and the column/row counters.
- Adds start-bit glitch rejection, framing-error reporting and a busy flag for the host flow-control logic.

Parameters:
- CLKS_PER_BIT, 54, clock cycles per serial bit period. Must be ≥4 and even.
- SYNC_STAGES, 2, number of metastability flops on `uart_rx`. Must be ≥2.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- uart_rx  in  1  raw serial line; idle high, LSB-first, 1 start bit, 8 data bits, 1 stop bit.
- uart_data  out  8  last correctly framed byte; held until the next good frame.
- uart_data_rdy  out  1  one-cycle pulse when `uart_data` has just been updated.
- framing_err  out  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high): all synchronizer flops are set to 1 (line idle). `uart_data`=0, `uart_data_rdy`=0, `framing_err`=0, `rx_busy`=0, state=IDLE, bit counter=0, clock counter=0.
- rx_s is `uart_rx` after SYNC_STAGES flops. All decisions use rx_s only.
- Clock counter `clk_cnt` is $clog2(CLKS_PER_BIT) bits wide. It is cleared on every state transition; it counts up otherwise.
- States:
  - IDLE: when rx_s==0, go to START with clk_cnt=0.
  - START: when clk_cnt==CLKS_PER_BIT/2-1, sample rx_s (mid start bit).
    - rx_s==0: go to DATA with bit_idx=0.
    - rx_s==1: glitch; return to IDLE. No pulse on any output.
  - DATA: when clk_cnt==CLKS_PER_BIT-1, sample rx_s into the shift register. The register shifts right and the new bit enters at bit 7, so the byte is LSB-first. bit_idx then increments. After the sample with bit_idx==7, go to STOP.
  - STOP: when clk_cnt==CLKS_PER_BIT-1, sample rx_s.
    - rx_s==1: load `uart_data` from the shift register, pulse `uart_data_rdy` for exactly 1 cycle (the cycle after the sample edge), go to IDLE.
    - rx_s==0: pulse `framing_err` for 1 cycle, leave `uart_data` unchanged, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. A held-low line (break condition) therefore never produces spurious bytes.
- Timing: the start edge is seen at cycle t, the first cycle with rx_s==0.
  - Data bit i is sampled at t+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
  - The stop bit is sampled at t+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
  - `uart_data_rdy` is high on the following cycle.
  - Total pin-to-strobe latency is that sample time plus SYNC_STAGES cycles.
- Back-to-back frames: after a good stop sample the FSM is in IDLE about half a bit before the nominal stop end. A start edge arriving immediately after the stop bit must be accepted with no lost frame.
- `uart_data_rdy` and `framing_err` are never high in the same cycle. Neither is ever high for more than one cycle.
- There is no backpressure: the consumer must accept the strobe in the cycle it is asserted. The host is throttled via `uart_rts`, which is not in this block.
- Reset asserted mid-frame: state returns to IDLE immediately. The partial byte is discarded and no strobe is issued. After release, the next falling edge on rx_s starts a new frame. Reception resynchronizes on a true idle-to-start transition.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}.
  - Constant UART_CLKS_PER_BIT=54, reused by the transmitter.
  - Constant UART_DATA_BITS=8.
- Sub-module uart_sync: parameterised SYNC_STAGES flop chain with asynchronous preset-to-1 on reset. Reusable for `uart_cts`.

Test Plan (CLKS_PER_BIT=8 unless stated):
- Single frame 0xA5, ideal timing → one `uart_data_rdy` pulse; `uart_data`=0xA5; `framing_err` stays 0; `rx_busy` high for about 10 bit periods.
- Three back-to-back frames 0x00, 0xFF, 0x3C with no idle gap → exactly three strobes, values in order, none dropped.
- Low glitch of 3 cycles on an idle line → no strobe, no `framing_err`; FSM back in IDLE; `rx_busy` pulses then clears.
- Frame 0x5A with the stop bit forced low, then the line held low 20 bit periods, then frame 0x11 → one `framing_err` pulse; `uart_data` still holds its previous value (0 after reset); no strobes during the break; then strobe with 0x11.
- Reset asserted during data bit 4 of frame 0x77, released, then frame 0x88 → no strobe for 0x77; `uart_data`=0 after reset; then single strobe with 0x88.
- CLKS_PER_BIT=54, bit period skewed ±3% on 0xC3 → correct byte received in both cases.
